// File: rtl/ping_pong_ctrl_n.sv
// Two-bank ping-pong sequencer for the NORTH buffer.
// The producer fills one bank while the matmul consumer drains the other bank NUM_PASSES times.
// All bank strobes are decoded combinationally from the same-cycle fire, and read data is
// valid one cycle after the read address is issued.
//
// State  | meaning (per bank)
// -------+--------------------------------------------------------------
// EMPTY  | free; the write side may start a new fill here
// FILLING| partially written; the write side is still filling it
// FULL   | fully written; waiting for the read side
// DRAINING| being read; released after the last word of the last pass
module ping_pong_ctrl_n #(
  parameter int TOTAL_MODULES = 3,
  parameter int TOTAL_DEPTH   = 16,
  parameter int NUM_PASSES    = 2,
  localparam int ADDR_WIDTH   = $clog2(TOTAL_DEPTH),
  localparam int SLICE_W      = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  rd_bank_sel,
  output logic [SLICE_W-1:0]    slicing_idx,
  output logic [1:0]            bank_full,
  output logic                  bank0_ena,
  output logic                  bank0_wea,
  output logic [ADDR_WIDTH-1:0] bank0_addra,
  output logic                  bank1_ena,
  output logic                  bank1_wea,
  output logic [ADDR_WIDTH-1:0] bank1_addra
);

  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_state_t;

  bank_state_t             r_state [2];
  bank_state_t             w_state_nxt [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [PASS_W-1:0]       r_pass_cnt;
  logic [SLICE_W-1:0]      r_slice;
  logic                    r_run;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic                    r_rd_sel;
  logic [1:0]              r_bank_full;

  logic                    w_wr_ok;
  logic                    w_rd_ok;
  logic                    w_wr_fire;
  logic                    w_rd_fire;
  logic                    w_wr_end;
  logic                    w_rd_wrap;
  logic                    w_rd_end;

  // r_run keeps in_ready low while reset is held and until the first clock after release.
  assign w_wr_ok   = (r_state[r_wr_ptr] == ST_EMPTY) || (r_state[r_wr_ptr] == ST_FILLING);
  assign w_rd_ok   = (r_state[r_rd_ptr] == ST_FULL)  || (r_state[r_rd_ptr] == ST_DRAINING);
  assign in_ready  = r_run & w_wr_ok;
  assign w_wr_fire = in_valid & in_ready & ~clear;
  assign w_rd_fire = out_ready & w_rd_ok & ~clear;
  assign w_wr_end  = (r_wr_addr == ADDR_WIDTH'(TOTAL_DEPTH - 1));
  assign w_rd_wrap = (r_rd_addr == ADDR_WIDTH'(TOTAL_DEPTH - 1));
  assign w_rd_end  = w_rd_wrap && (r_pass_cnt == PASS_W'(NUM_PASSES - 1));

  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign rd_bank_sel = r_rd_sel;
  assign slicing_idx = r_slice;
  assign bank_full   = r_bank_full;

  // Per-bank state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '{ST_EMPTY, ST_EMPTY};
    end else if (clear) begin
      r_state <= '{ST_EMPTY, ST_EMPTY};
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next bank state and bank strobes; the two sides never target the same bank.
  always_comb begin
    w_state_nxt = r_state;
    bank0_ena   = 1'b0;
    bank0_wea   = 1'b0;
    bank0_addra = '0;
    bank1_ena   = 1'b0;
    bank1_wea   = 1'b0;
    bank1_addra = '0;
    if (w_wr_fire) begin
      w_state_nxt[r_wr_ptr] = w_wr_end ? ST_FULL : ST_FILLING;
      if (r_wr_ptr) begin
        bank1_ena   = 1'b1;
        bank1_wea   = 1'b1;
        bank1_addra = r_wr_addr;
      end else begin
        bank0_ena   = 1'b1;
        bank0_wea   = 1'b1;
        bank0_addra = r_wr_addr;
      end
    end
    if (w_rd_fire) begin
      w_state_nxt[r_rd_ptr] = w_rd_end ? ST_EMPTY : ST_DRAINING;
      if (r_rd_ptr) begin
        bank1_ena   = 1'b1;
        bank1_addra = r_rd_addr;
      end else begin
        bank0_ena   = 1'b1;
        bank0_addra = r_rd_addr;
      end
    end
  end

  // Pointers, address/pass counters, slice index and registered read-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_pass_cnt  <= '0;
      r_slice     <= '0;
      r_run       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_bank_full <= 2'b00;
    end else if (clear) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_pass_cnt  <= '0;
      r_slice     <= '0;
      r_run       <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_bank_full <= 2'b00;
    end else begin
      r_run       <= 1'b1;
      r_out_valid <= w_rd_fire;
      r_out_last  <= w_rd_fire & w_rd_end;
      if (w_rd_fire) begin
        r_rd_sel <= r_rd_ptr;
      end
      if (w_wr_fire) begin
        if (w_wr_end) begin
          r_wr_addr <= '0;
          r_wr_ptr  <= ~r_wr_ptr;
          r_slice   <= (r_slice == SLICE_W'(TOTAL_MODULES - 1)) ? '0 : r_slice + SLICE_W'(1);
        end else begin
          r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
        end
      end
      if (w_rd_fire) begin
        if (w_rd_wrap) begin
          r_rd_addr <= '0;
          if (w_rd_end) begin
            r_pass_cnt <= '0;
            r_rd_ptr   <= ~r_rd_ptr;
          end else begin
            r_pass_cnt <= r_pass_cnt + PASS_W'(1);
          end
        end else begin
          r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
        end
      end
      for (int b = 0; b < 2; b++) begin
        r_bank_full[b] <= (w_state_nxt[b] == ST_FULL) || (w_state_nxt[b] == ST_DRAINING);
      end
    end
  end

endmodule

// File: tb/tb_ping_pong_ctrl_n.sv
// Bench for ping_pong_ctrl_n: directed stimulus, a per-cycle comparison against a
// fill-count/read-count model of the two banks, and hand-computed literal expectations.
module tb_ping_pong_ctrl_n;
  localparam int DEPTH  = 16;
  localparam int PASSES = 2;
  localparam int MODS   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_last;
  logic       rd_bank_sel;
  logic [1:0] slicing_idx;
  logic [1:0] bank_full;
  logic       bank0_ena, bank0_wea, bank1_ena, bank1_wea;
  logic [3:0] bank0_addra, bank1_addra;

  ping_pong_ctrl_n #(.TOTAL_MODULES(MODS), .TOTAL_DEPTH(DEPTH), .NUM_PASSES(PASSES)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
    .rd_bank_sel(rd_bank_sel), .slicing_idx(slicing_idx), .bank_full(bank_full),
    .bank0_ena(bank0_ena), .bank0_wea(bank0_wea), .bank0_addra(bank0_addra),
    .bank1_ena(bank1_ena), .bank1_wea(bank1_wea), .bank1_addra(bank1_addra)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: per bank, how many beats are written and how many reads were issued.
  int m_wcnt [2];
  int m_rdone [2];
  int m_slice;
  bit m_wp, m_rp, m_run, m_ov, m_last, m_sel;
  int word_cnt = 0;
  int last_word = 0;

  task automatic model_reset(input bit run);
    m_wcnt[0] = 0; m_wcnt[1] = 0;
    m_rdone[0] = 0; m_rdone[1] = 0;
    m_slice = 0; m_wp = 0; m_rp = 0;
    m_ov = 0; m_last = 0; m_sel = 0;
    m_run = run;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model, then advance the model across the next edge.
  task automatic model_step();
    bit rdy, wf, rf, wb, rb;
    bit e_ena [2];
    bit e_wea [2];
    logic [3:0] e_addr [2];
    logic [19:0] e, a;
    if (!rst_n) model_reset(0);
    rdy = m_run && (m_wcnt[m_wp] < DEPTH);
    wf  = in_valid && rdy && !clear;
    rf  = out_ready && (m_wcnt[m_rp] == DEPTH) && !clear;
    wb  = m_wp;
    rb  = m_rp;
    e_ena[0] = 0; e_ena[1] = 0; e_wea[0] = 0; e_wea[1] = 0;
    e_addr[0] = '0; e_addr[1] = '0;
    if (wf) begin
      e_ena[wb] = 1; e_wea[wb] = 1; e_addr[wb] = 4'(m_wcnt[wb]);
    end
    if (rf) begin
      e_ena[rb] = 1; e_addr[rb] = 4'(m_rdone[rb] % DEPTH);
    end
    e = {rdy, m_ov, m_last, m_sel, 2'(m_slice), (m_wcnt[1] == DEPTH), (m_wcnt[0] == DEPTH),
         e_ena[0], e_wea[0], e_addr[0], e_ena[1], e_wea[1], e_addr[1]};
    a = {in_ready, out_valid, out_last, rd_bank_sel, slicing_idx, bank_full,
         bank0_ena, bank0_wea, bank0_addra, bank1_ena, bank1_wea, bank1_addra};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t {rdy,ov,last,sel,slice,full,b0 ena/wea/addr,b1 ena/wea/addr} got %05h expected %05h",
               $time, a, e);
    end
    if (out_valid === 1'b1) word_cnt++;
    if (out_last === 1'b1) last_word = word_cnt;
    if (rst_n) begin
      if (clear) begin
        model_reset(1);
      end else begin
        m_last = rf && (m_rdone[rb] == PASSES * DEPTH - 1);
        m_ov   = rf;
        if (rf) m_sel = rb;
        if (wf) begin
          m_wcnt[wb]++;
          if (m_wcnt[wb] == DEPTH) begin
            m_wp    = !wb;
            m_slice = (m_slice + 1) % MODS;
          end
        end
        if (rf) begin
          m_rdone[rb]++;
          if (m_rdone[rb] == PASSES * DEPTH) begin
            m_rdone[rb] = 0;
            m_wcnt[rb]  = 0;
            m_rp        = !rb;
          end
        end
        m_run = 1;
      end
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, return just after the rising edge.
  task automatic cyc(input logic iv, input logic ordy, input logic clr);
    in_valid  = iv;
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  int base;
  int exp_slice [4] = '{0, 1, 2, 0};

  initial begin
    model_reset(0);
    @(posedge clk); #1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("in_ready_after_release", in_ready, 1);
    chk("reset_slicing_idx", slicing_idx, 0);

    // Fill bank0 then drain it twice.
    base = word_cnt;
    repeat (16) cyc(1, 1, 0);
    chk("t1_slicing_after_fill", slicing_idx, 1);
    chk("t1_bank_full", bank_full, 2'b01);
    repeat (34) cyc(0, 1, 0);
    chk("t1_words", word_cnt - base, 32);
    chk("t1_last_word", last_word - base, 32);
    chk("t1_bank_full_after", bank_full, 0);

    // Clear in the middle of the second fill (bank1 full, bank0 at address 7).
    repeat (16) cyc(1, 0, 0);
    chk("t5_slicing_pre", slicing_idx, 2);
    chk("t5_full_pre", bank_full, 2'b10);
    repeat (7) cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk("t5_bank_full", bank_full, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_slicing_idx", slicing_idx, 0);
    chk("t5_out_valid", out_valid, 0);

    // Four fill/drain rounds; the second drain toggles out_ready every cycle.
    for (int f = 0; f < 4; f++) begin
      chk("t4_slicing_seq", slicing_idx, exp_slice[f]);
      base = word_cnt;
      repeat (16) cyc(1, 1, 0);
      if (f == 1) begin
        for (int i = 0; i < 66; i++) cyc(0, (i % 2) == 0, 0);
      end else begin
        repeat (34) cyc(0, 1, 0);
      end
      chk("t34_words", word_cnt - base, 32);
      chk("t34_last_word", last_word - base, 32);
      chk("t34_empty", bank_full, 0);
    end

    // Continuous producer and consumer.
    repeat (40) cyc(1, 1, 0);
    chk("t2_both_full", bank_full, 2'b11);
    chk("t2_in_ready_low", in_ready, 0);
    chk("t2_rd_bank_sel", rd_bank_sel, 0);
    repeat (60) cyc(1, 1, 0);
    repeat (52) cyc(0, 1, 0);
    chk("t2_drained", bank_full, 0);
    chk("t2_slicing", slicing_idx, 2);

    // Asynchronous reset in the middle of a drain.
    repeat (16) cyc(1, 0, 0);
    repeat (10) cyc(0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_bank_full", bank_full, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_bank0_ena", bank0_ena, 0);
    chk("t6_slicing", slicing_idx, 0);
    cyc(0, 1, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("t6_in_ready_after", in_ready, 1);
    in_valid = 1'b1;
    #1;
    chk("t6_first_write", {bank0_ena, bank0_wea, bank0_addra, bank1_ena}, {1'b1, 1'b1, 4'd0, 1'b0});
    base = word_cnt;
    repeat (16) cyc(1, 1, 0);
    repeat (34) cyc(0, 1, 0);
    chk("t6_words", word_cnt - base, 32);
    chk("t6_slicing_end", slicing_idx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
